// File: rtl/rtc_bus_cycle_ctrl_if.sv
// rtc_bus_cycle_ctrl_if: request, pad and strobe signals between an RTC bus controller and its user
interface rtc_bus_cycle_ctrl_if #(parameter int lar = 8);
  logic           start_wr;
  logic           start_rd;
  logic [lar-1:0] Dir;
  logic [lar-1:0] Dato;
  logic [lar-1:0] bus_in;
  logic [lar-1:0] bus_out;
  logic           bus_oe;
  logic           AD;
  logic           CS;
  logic           WR;
  logic           RD;
  logic [lar-1:0] Dato_leido;
  logic           busy;
  logic           done;
  modport master (
    output start_wr, start_rd, Dir, Dato, bus_in,
    input  bus_out, bus_oe, AD, CS, WR, RD, Dato_leido, busy, done
  );
  modport slave (
    input  start_wr, start_rd, Dir, Dato, bus_in,
    output bus_out, bus_oe, AD, CS, WR, RD, Dato_leido, busy, done
  );
endinterface

// File: rtl/rtc_bus_cycle_ctrl.sv
// rtc_bus_cycle_ctrl: multiplexed AD bus sequencer for an RTC, five T_PH-cycle phases plus a one-cycle finish
module rtc_bus_cycle_ctrl #(
  parameter int lar  = 8,
  parameter int T_PH = 4
) (
  input  logic                clk,
  input  logic                rst,
  rtc_bus_cycle_ctrl_if.slave b
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_HOLD, GAP, DATA, DATA_HOLD, FIN} state_t;
  state_t         r_state, w_nxt;
  logic [7:0]     r_cnt, w_cnt;
  logic           r_op_wr, w_op_wr, w_start, w_last, w_ap, w_dp;
  logic [lar-1:0] r_dir, r_dat, w_dir, w_dat;
  logic           r_ad, r_cs, r_wr_n, r_rd_n, r_oe, r_busy, r_done;
  logic [lar-1:0] r_bus_out, r_rdata;
  // outputs are registered from the next state so each strobe changes exactly on the phase edge
  always_comb begin
    w_start = r_state == IDLE && (b.start_wr || b.start_rd);
    w_last  = r_cnt == 8'(T_PH - 1);
    w_nxt   = w_start ? ADDR :
              r_state == FIN ? IDLE :
              (r_state != IDLE && w_last) ? state_t'(r_state + 3'd1) : r_state;
    w_cnt   = (r_state == IDLE || r_state == FIN || w_last) ? 8'd0 : r_cnt + 8'd1;
    w_op_wr = w_start ? b.start_wr : r_op_wr;
    w_dir   = w_start ? b.Dir : r_dir;
    w_dat   = w_start ? b.Dato : r_dat;
    w_ap    = w_nxt == ADDR || w_nxt == ADDR_HOLD;
    w_dp    = w_nxt == DATA || w_nxt == DATA_HOLD;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= 8'd0;
      r_op_wr   <= 1'b0;
      r_dir     <= '0;
      r_dat     <= '0;
      r_ad      <= 1'b1;
      r_cs      <= 1'b1;
      r_wr_n    <= 1'b1;
      r_rd_n    <= 1'b1;
      r_oe      <= 1'b0;
      r_bus_out <= '0;
      r_rdata   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_cnt     <= w_cnt;
      r_op_wr   <= w_op_wr;
      r_dir     <= w_dir;
      r_dat     <= w_dat;
      r_ad      <= !w_ap;
      r_cs      <= !(w_ap || w_dp);
      r_wr_n    <= !(w_nxt == ADDR || (w_nxt == DATA && w_op_wr));
      r_rd_n    <= !(w_nxt == DATA && !w_op_wr);
      r_oe      <= w_ap || (w_dp && w_op_wr);
      r_bus_out <= w_ap ? w_dir : (w_dp && w_op_wr) ? w_dat : r_bus_out;
      r_busy    <= w_nxt != IDLE;
      r_done    <= w_nxt == FIN;
      if (r_state == DATA && w_last && !r_op_wr) r_rdata <= b.bus_in;
    end
  end
  assign b.AD         = r_ad;
  assign b.CS         = r_cs;
  assign b.WR         = r_wr_n;
  assign b.RD         = r_rd_n;
  assign b.bus_oe     = r_oe;
  assign b.bus_out    = r_bus_out;
  assign b.Dato_leido = r_rdata;
  assign b.busy       = r_busy;
  assign b.done       = r_done;
endmodule

// File: tb/tb_rtc_bus_cycle_ctrl.sv
// tb_rtc_bus_cycle_ctrl: directed scenarios plus randomized traffic against a cycle-offset reference model
module tb_rtc_bus_cycle_ctrl;
  localparam int L = 8;
  localparam int T = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  rtc_bus_cycle_ctrl_if #(.lar(L)) bus ();
  rtc_bus_cycle_ctrl #(.lar(L), .T_PH(T)) dut (.clk(clk), .rst(rst), .b(bus.slave));
  always #5 clk = ~clk;
  // model: cycles elapsed since the accepting edge decide the phase
  bit         m_busy = 0;
  int         m_t = 0;
  bit         m_wr = 0;
  logic [7:0] m_dir = 0, m_dat = 0, m_rdata = 0;
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_t = 0; m_rdata = 0;
    end else if (!m_busy) begin
      if (bus.start_wr || bus.start_rd) begin
        m_busy = 1; m_t = 1; m_wr = bus.start_wr; m_dir = bus.Dir; m_dat = bus.Dato;
      end
    end else if (m_t == 5*T + 1) begin
      m_busy = 0; m_t = 0;
    end else begin
      if (!m_wr && m_t == 4*T) m_rdata = bus.bus_in;
      m_t++;
    end
    #1;
  endtask
  function automatic logic [6:0] ctl();
    return {bus.AD, bus.CS, bus.WR, bus.RD, bus.bus_oe, bus.busy, bus.done};
  endfunction
  task automatic do_reset();
    rst = 1; bus.start_wr = 0; bus.start_rd = 0;
    tick();
    rst = 0;
  endtask
  task automatic test_reset();
    rst = 1; bus.start_wr = 1; bus.start_rd = 1; bus.Dir = 8'hAA; bus.Dato = 8'h55;
    tick(); tick();
    total++; if (ctl() !== 7'b1111000) begin bad++; $display("FAIL rst_ctl got=%b exp=1111000", ctl()); end
    total++; if (bus.bus_out !== 8'h00) begin bad++; $display("FAIL rst_bus_out got=%h exp=00", bus.bus_out); end
    total++; if (bus.Dato_leido !== 8'h00) begin bad++; $display("FAIL rst_dato_leido got=%h exp=00", bus.Dato_leido); end
    rst = 0; bus.start_wr = 0; bus.start_rd = 0;
    tick();
    total++; if (ctl() !== 7'b1111000) begin bad++; $display("FAIL rst_idle got=%b exp=1111000", ctl()); end
  endtask
  task automatic test_write();
    do_reset();
    bus.Dir = 8'h21; bus.Dato = 8'h45; bus.start_wr = 1;
    tick();
    bus.start_wr = 0;
    for (int c = 1; c <= 22; c++) begin
      if (c <= 8) begin
        total++; if (bus.AD !== 0 || bus.bus_out !== 8'h21 || bus.WR !== (c > 4)) begin
          bad++; $display("FAIL wr_addr c=%0d AD=%b bus_out=%h WR=%b exp AD=0 bus_out=21 WR=%b", c, bus.AD, bus.bus_out, bus.WR, c > 4);
        end
      end else if (c <= 12) begin
        total++; if (bus.CS !== 1) begin bad++; $display("FAIL wr_gap c=%0d CS=%b exp=1", c, bus.CS); end
      end else if (c <= 16) begin
        total++; if (bus.WR !== 0 || bus.bus_out !== 8'h45 || bus.bus_oe !== 1) begin
          bad++; $display("FAIL wr_data c=%0d WR=%b bus_out=%h oe=%b exp WR=0 bus_out=45 oe=1", c, bus.WR, bus.bus_out, bus.bus_oe);
        end
      end
      total++; if (bus.done !== (c == 21)) begin bad++; $display("FAIL wr_done c=%0d got=%b exp=%b", c, bus.done, c == 21); end
      tick();
    end
  endtask
  task automatic test_read();
    do_reset();
    bus.Dir = 8'h22; bus.start_rd = 1; bus.bus_in = 8'hA5;
    tick();
    bus.start_rd = 0;
    for (int c = 1; c <= 22; c++) begin
      bus.bus_in = (c >= 13 && c <= 16) ? 8'h59 : 8'hA5;
      total++; if (bus.RD !== !(c >= 13 && c <= 16)) begin bad++; $display("FAIL rd_rd c=%0d got=%b exp=%b", c, bus.RD, !(c >= 13 && c <= 16)); end
      if (c >= 9) begin
        total++; if (bus.bus_oe !== 0) begin bad++; $display("FAIL rd_oe c=%0d got=%b exp=0", c, bus.bus_oe); end
      end
      total++; if (bus.Dato_leido !== (c >= 17 ? 8'h59 : 8'h00)) begin
        bad++; $display("FAIL rd_data c=%0d got=%h exp=%h", c, bus.Dato_leido, c >= 17 ? 8'h59 : 8'h00);
      end
      total++; if (bus.done !== (c == 21)) begin bad++; $display("FAIL rd_done c=%0d got=%b exp=%b", c, bus.done, c == 21); end
      tick();
    end
  endtask
  task automatic test_both();
    do_reset();
    bus.Dir = 8'h30; bus.Dato = 8'h7E; bus.start_wr = 1; bus.start_rd = 1;
    tick();
    bus.start_wr = 0; bus.start_rd = 0;
    for (int c = 1; c <= 21; c++) begin
      total++; if (bus.RD !== 1) begin bad++; $display("FAIL both_rd c=%0d got=%b exp=1", c, bus.RD); end
      if (c == 13) begin
        total++; if (bus.WR !== 0 || bus.bus_out !== 8'h7E) begin
          bad++; $display("FAIL both_wr c=%0d WR=%b bus_out=%h exp WR=0 bus_out=7e", c, bus.WR, bus.bus_out);
        end
      end
      tick();
    end
  endtask
  task automatic test_ignore();
    do_reset();
    bus.Dir = 8'h11; bus.Dato = 8'h22; bus.start_wr = 1;
    tick();
    bus.start_wr = 0;
    for (int c = 1; c <= 30; c++) begin
      bus.start_rd = (c == 5);
      total++; if (bus.busy !== (c <= 21) || (c > 21 && bus.AD !== 1)) begin
        bad++; $display("FAIL ign_busy c=%0d busy=%b AD=%b exp busy=%b", c, bus.busy, bus.AD, c <= 21);
      end
      tick();
    end
    bus.start_rd = 0;
  endtask
  task automatic test_abort();
    do_reset();
    bus.Dir = 8'h22; bus.start_rd = 1; bus.bus_in = 8'h33;
    tick();
    bus.start_rd = 0;
    for (int c = 1; c <= 25; c++) begin
      rst = (c == 14);
      if (c >= 15) begin
        total++; if (ctl() !== 7'b1111000 || bus.bus_out !== 8'h00 || bus.Dato_leido !== 8'h00) begin
          bad++; $display("FAIL abort c=%0d ctl=%b bus_out=%h dl=%h exp ctl=1111000 bus_out=00 dl=00", c, ctl(), bus.bus_out, bus.Dato_leido);
        end
      end
      tick();
    end
    rst = 0;
  endtask
  task automatic test_back_to_back();
    do_reset();
    bus.Dir = 8'h44; bus.Dato = 8'h99; bus.start_wr = 1;
    tick();
    for (int c = 1; c <= 23; c++) begin
      if (c == 21) begin
        total++; if (bus.done !== 1) begin bad++; $display("FAIL b2b_done c=21 got=%b exp=1", bus.done); end
      end
      if (c == 22) begin
        total++; if (bus.busy !== 0 || bus.AD !== 1) begin bad++; $display("FAIL b2b_idle c=22 busy=%b AD=%b exp 0 1", bus.busy, bus.AD); end
      end
      if (c == 23) begin
        total++; if (bus.busy !== 1 || bus.AD !== 0 || bus.CS !== 0) begin
          bad++; $display("FAIL b2b_addr c=23 busy=%b AD=%b CS=%b exp 1 0 0", bus.busy, bus.AD, bus.CS);
        end
      end
      if (c < 23) tick();
    end
    bus.start_wr = 0;
  endtask
  task automatic test_random();
    int p;
    logic [6:0] ev;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      bus.start_wr = ($urandom_range(0, 5) == 0);
      bus.start_rd = ($urandom_range(0, 5) == 0);
      bus.Dir = 8'($urandom); bus.Dato = 8'($urandom); bus.bus_in = 8'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      tick();
      p = m_busy ? (m_t - 1) / T : 7;
      ev = {!(p < 2), !(p < 2 || p == 3 || p == 4), !(p == 0 || (p == 3 && m_wr)), !(p == 3 && !m_wr),
            p < 2 || ((p == 3 || p == 4) && m_wr), m_busy, p == 5};
      total++; if (ctl() !== ev) begin bad++; $display("FAIL rnd_ctl n=%0d got=%b exp=%b", n, ctl(), ev); end
      total++; if (bus.Dato_leido !== m_rdata) begin bad++; $display("FAIL rnd_dl n=%0d got=%h exp=%h", n, bus.Dato_leido, m_rdata); end
      if (ev[2]) begin
        total++; if (bus.bus_out !== (p < 2 ? m_dir : m_dat)) begin
          bad++; $display("FAIL rnd_bus_out n=%0d got=%h exp=%h", n, bus.bus_out, p < 2 ? m_dir : m_dat);
        end
      end
      total++; if ((!bus.WR && !bus.RD) || (bus.bus_oe && !bus.RD)) begin
        bad++; $display("FAIL rnd_excl n=%0d WR=%b RD=%b oe=%b exp no overlap", n, bus.WR, bus.RD, bus.bus_oe);
      end
    end
    rst = 0; bus.start_wr = 0; bus.start_rd = 0;
  endtask
  initial begin
    bus.start_wr = 0; bus.start_rd = 0; bus.Dir = 0; bus.Dato = 0; bus.bus_in = 0;
    test_reset();
    test_write();
    test_read();
    test_both();
    test_ignore();
    test_abort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
